// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch-to-decode bus layout, exception encodings
// and the fetch-queue entry record.
package pipeline_pkg;

   localparam logic [31:0] NOP_INST      = 32'h0000_0033;
   localparam int          EXC_VALID_BIT = 5;
   localparam int          IF_ID_BUS_W   = 64;

   typedef logic [5:0] exc_code_t;

   localparam exc_code_t EXC_NONE          = 6'b000000;
   localparam exc_code_t EXC_INST_MISALIGN = 6'b100000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      exc_code_t   exc;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {inst, pc, exc} records with flush.
// The head reads as all-zero whenever the queue is empty.
module fetch_queue
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        push,
   input  fq_entry_t   push_data,
   input  logic        pop,
   output fq_entry_t   head,
   output logic [AW:0] count,
   output logic        empty
);

   fq_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            full;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues 1-cycle-latency SRAM fetches under a credit
// limit, queues responses, and hands {inst, pc, exc} to decode via valid/allowin.
module if_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   inst_sram_en,
   output logic [31:0]            inst_sram_addr,
   input  logic [31:0]            inst_sram_rdata,
   input  logic                   br_jmp_flag,
   input  logic [31:0]            br_target,
   input  logic                   trap_flag,
   input  logic [31:0]            trap_target,
   input  logic                   ds_allowin,
   output logic                   fs_to_ds_valid,
   output logic [IF_ID_BUS_W-1:0] if_id_bus_out,
   output exc_code_t              exception_code_fd
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   // Handshake: decode takes the head entry in any cycle where
   // fs_to_ds_valid && ds_allowin; valid never depends on ds_allowin.

   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic          inflight;
   logic          halt;

   logic          redirect;
   logic [31:0]   target;
   logic          active;
   logic          misalign;
   logic          credit;
   logic [CW:0]   occ;
   logic          issue;
   logic          exc_push;
   logic          resp_push;
   logic          pop;
   logic [CW-1:0] count;
   logic          empty;
   fq_entry_t     push_data;
   fq_entry_t     head;

   assign redirect = trap_flag | br_jmp_flag;
   assign target   = trap_flag ? trap_target : br_target;
   assign active   = !rst && !redirect;
   assign misalign = (fetch_pc[1:0] != 2'b00);

   assign fs_to_ds_valid = active && !empty;
   assign pop            = fs_to_ds_valid && ds_allowin;

   // Credit counts the slot freed by a same-cycle pop so the stage sustains
   // one fetch per cycle with only FQ_DEPTH entries of buffering.
   assign occ    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign credit = (occ < (CW+1)'(FQ_DEPTH));

   assign issue     = active && !halt && !misalign && credit;
   assign exc_push  = active && !halt && misalign && !inflight && credit;
   // A response landing in a redirect cycle is wrong-path; gating on active drops it.
   assign resp_push = active && inflight;

   always_comb begin
      push_data = '0;
      if (exc_push) begin
         push_data.inst = NOP_INST;
         push_data.pc   = fetch_pc;
         push_data.exc  = EXC_INST_MISALIGN;
      end else begin
         push_data.inst = inst_sram_rdata;
         push_data.pc   = req_pc;
         push_data.exc  = EXC_NONE;
      end
   end

   assign inst_sram_en      = issue;
   assign inst_sram_addr    = fetch_pc;
   assign if_id_bus_out     = {head.inst, head.pc};
   assign exception_code_fd = head.exc;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
         halt     <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) req_pc <= fetch_pc;
         if (redirect) begin
            fetch_pc <= target;
            halt     <= 1'b0;
         end else begin
            if (issue)    fetch_pc <= fetch_pc + 32'd4;
            if (exc_push) halt     <= 1'b1;
         end
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_fq (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (resp_push || exc_push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .empty     (empty)
   );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: SRAM model returning ~addr, in-order scoreboard of
// delivered {inst, pc, exc}, redirect vector table plus reset/stall sequences.
module tb_if_stage;
   import pipeline_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   inst_sram_en;
   logic [31:0]            inst_sram_addr;
   logic [31:0]            inst_sram_rdata;
   logic                   br_jmp_flag;
   logic [31:0]            br_target;
   logic                   trap_flag;
   logic [31:0]            trap_target;
   logic                   ds_allowin;
   logic                   fs_to_ds_valid;
   logic [IF_ID_BUS_W-1:0] if_id_bus_out;
   exc_code_t              exception_code_fd;

   typedef struct {
      logic        br;
      logic        trap;
      logic [31:0] bt;
      logic [31:0] tt;
      logic [31:0] exp_pc;
      logic        exp_exc;
   } vec_t;

   vec_t        vecs [7];
   logic [69:0] exp_q [$];
   int          tests = 0;
   int          fails = 0;
   int          acc_cnt;
   int          en_cnt;
   int          cyc_n;
   int          first_valid;

   if_stage #(
      .RESET_PC (32'h0000_0000),
      .FQ_DEPTH (2)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .inst_sram_en      (inst_sram_en),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_rdata   (inst_sram_rdata),
      .br_jmp_flag       (br_jmp_flag),
      .br_target         (br_target),
      .trap_flag         (trap_flag),
      .trap_target       (trap_target),
      .ds_allowin        (ds_allowin),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .if_id_bus_out     (if_id_bus_out),
      .exception_code_fd (exception_code_fd)
   );

   always #5 clk = ~clk;

   // SRAM with 1-cycle read latency; data is ~addr so inst and pc differ.
   always @(posedge clk) begin
      if (inst_sram_en) inst_sram_rdata <= ~inst_sram_addr;
      else              inst_sram_rdata <= 32'hBAD0_BAD0;
   end

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_from(input logic [31:0] start, input int n);
      logic [31:0] pc;
      exp_q.delete();
      pc = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({~pc, pc, EXC_NONE});
         pc = pc + 32'd4;
      end
   endtask

   // One clock: sample at negedge, compare accepted output, return at posedge+1.
   task automatic cyc();
      @(negedge clk);
      en_cnt += int'(inst_sram_en);
      if (!rst && fs_to_ds_valid && first_valid < 0) first_valid = cyc_n;
      if (!rst && fs_to_ds_valid && ds_allowin) begin
         acc_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_output: got pc %h with no entry expected", if_id_bus_out[31:0]);
         end else begin
            check("deliver", {if_id_bus_out, exception_code_fd}, exp_q.pop_front());
         end
      end
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic br, input logic trap, input logic [31:0] bt,
                              input logic [31:0] tt);
      br_jmp_flag = br;
      trap_flag   = trap;
      br_target   = bt;
      trap_target = tt;
      @(negedge clk);
      check("redirect_valid", 70'(fs_to_ds_valid), 70'(0));
      check("redirect_no_issue", 70'(inst_sram_en), 70'(0));
      @(posedge clk);
      #1;
      br_jmp_flag = 1'b0;
      trap_flag   = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0100, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0300, 32'h0000_0200, 32'h0000_0200, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         32'h0000_0102, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0400, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_0500, 32'h0000_0203, 32'h0000_0203, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 32'h0,         32'h0000_0600, 32'h0000_0600, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'hFFFF_FFF8, 1'b0};

      rst         = 1'b1;
      ds_allowin  = 1'b1;
      br_jmp_flag = 1'b0;
      trap_flag   = 1'b0;
      br_target   = '0;
      trap_target = '0;
      acc_cnt     = 0;
      en_cnt      = 0;
      cyc_n       = 0;
      first_valid = -1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_en", 70'(inst_sram_en), 70'(0));
      check("rst_valid", 70'(fs_to_ds_valid), 70'(0));
      check("rst_bus", 70'(if_id_bus_out), 70'(0));
      check("rst_exc", 70'(exception_code_fd), 70'(0));

      // Reset release: stream from RESET_PC, first valid two cycles later.
      expect_from(32'h0, 128);
      rst = 1'b0;
      repeat (8) cyc();
      check_int("first_valid_latency", first_valid, 2);
      check_int("stream_after_reset", acc_cnt, 6);

      // Backpressure: queue fills, fetching stops, then drains in order.
      ds_allowin = 1'b0;
      en_cnt = 0;
      repeat (5) cyc();
      check_int("stall_issue_cnt", en_cnt, 0);
      check("stall_en_low", 70'(inst_sram_en), 70'(0));
      check("stall_valid", 70'(fs_to_ds_valid), 70'(1));
      ds_allowin = 1'b1;
      acc_cnt = 0;
      repeat (6) cyc();
      check_int("drain_count", acc_cnt, 6);

      // Random backpressure; ordering is covered by the scoreboard.
      acc_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         ds_allowin = ($urandom_range(0, 3) != 0);
         cyc();
      end
      ds_allowin = 1'b1;
      check_int("random_progress", int'(acc_cnt >= 10), 1);

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].exp_exc) begin
            exp_q.delete();
            exp_q.push_back({NOP_INST, vecs[v].exp_pc, EXC_INST_MISALIGN});
         end else begin
            expect_from(vecs[v].exp_pc, 32);
         end
         do_redirect(vecs[v].br, vecs[v].trap, vecs[v].bt, vecs[v].tt);
         acc_cnt = 0;
         en_cnt  = 0;
         repeat (12) cyc();
         if (vecs[v].exp_exc) begin
            check_int("misalign_count", acc_cnt, 1);
            check_int("halt_no_fetch", en_cnt, 0);
         end else begin
            check_int("redirect_stream_count", acc_cnt, 10);
         end
      end

      // Mid-stream reset drops everything and restarts at RESET_PC.
      rst = 1'b1;
      cyc();
      check("midrst_en", 70'(inst_sram_en), 70'(0));
      check("midrst_valid", 70'(fs_to_ds_valid), 70'(0));
      check("midrst_bus", 70'(if_id_bus_out), 70'(0));
      check("midrst_exc", 70'(exception_code_fd), 70'(0));
      expect_from(32'h0, 32);
      rst = 1'b0;
      acc_cnt = 0;
      cyc_n = 0;
      first_valid = -1;
      repeat (6) cyc();
      check_int("midrst_first_valid", first_valid, 2);
      check_int("midrst_stream_count", acc_cnt, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
